// File: rtl/lsu_bus_if.sv
// Load/store unit driving a req/gnt/rvalid data bus ahead of the MEM stage.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              lsu_valid_i,
  input  logic              lsu_is_load_i,
  input  logic [2:0]        lsu_funct3_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              mem_r_ena_o,
  output logic [DATA_W-1:0] mem_r_data_o,
  output logic [ADDR_W-1:0] mem_r_addr_o,
  output logic              lsu_done_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                is_load_q, is_load_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                flushed_q, flushed_d;
  logic                mis_q, mis_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;

  logic                bad_f3;
  logic                mis_now;
  logic [ADDR_W-1:0]   addr_al;
  logic [3:0]          be;
  logic [DATA_W-1:0]   wd;

  function automatic logic [31:0] ld_ext(
    input logic [2:0]  f3,
    input logic [1:0]  a,
    input logic [31:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  ld_ext = {{24{b[7]}}, b};
      3'b100:  ld_ext = {24'h0, b};
      3'b001:  ld_ext = {{16{h[15]}}, h};
      3'b101:  ld_ext = {16'h0, h};
      3'b010:  ld_ext = w;
      default: ld_ext = '0;
    endcase
  endfunction

  // Classify the incoming access: legal funct3, alignment fix-up or trap
  always_comb begin
    if (lsu_is_load_i)
      bad_f3 = (lsu_funct3_i == 3'b011) ||
               (lsu_funct3_i[2:1] == 2'b11);
    else
      bad_f3 = lsu_funct3_i[2] ||
               (lsu_funct3_i == 3'b011);
    addr_al = lsu_addr_i;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_now = ((lsu_funct3_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
              ((lsu_funct3_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
`else
    mis_now = 1'b0;
    if (lsu_funct3_i[1:0] == 2'b01)
      addr_al[0] = 1'b0;
    if (lsu_funct3_i[1:0] == 2'b10)
      addr_al[1:0] = 2'b00;
`endif
  end

  // Byte enables and lane-steered write data from the captured access
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
      end
    endcase
  end

  // Transaction FSM: next state, captures and stall
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    flushed_d = flushed_q;
    mis_d     = mis_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    stall_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        flushed_d = 1'b0;
        mis_d     = 1'b0;
        if (lsu_valid_i && !flush_i) begin
          stall_o   = 1'b1;
          is_load_d = lsu_is_load_i;
          funct3_d  = lsu_funct3_i;
          addr_d    = addr_al;
          wdata_d   = lsu_wdata_i;
          if (bad_f3) begin
            state_d = S_DONE;
          end else if (mis_now) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (bus_gnt_i) begin
          if (is_load_q) begin
            flushed_d = flush_i;
            state_d   = S_WAIT;
          end else begin
            state_d = flush_i ? S_IDLE : S_DONE;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_o = !flushed_q;
        if (flush_i)
          flushed_d = 1'b1;
        if (bus_rvalid_i) begin
          if (flushed_q || flush_i) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = ld_ext(funct3_q, addr_q[1:0], bus_rdata_i);
            raddr_d = addr_q;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        rdata_d = '0;
        raddr_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and capture registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      is_load_q <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      flushed_q <= 1'b0;
      mis_q     <= 1'b0;
      rdata_q   <= '0;
      raddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      flushed_q <= flushed_d;
      mis_q     <= mis_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
    end
  end

  assign bus_req_o    = (state_q == S_REQ);
  assign bus_we_o     = bus_req_o && !is_load_q;
  assign bus_be_o     = bus_req_o ? be : 4'b0000;
  assign bus_addr_o   = bus_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_wdata_o  = bus_we_o ? wd : '0;
  assign lsu_done_o   = (state_q == S_DONE);
  assign mem_r_ena_o  = lsu_done_o && is_load_q && !mis_q;
  assign mem_r_data_o = rdata_q;
  assign mem_r_addr_o = raddr_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o   = lsu_done_o && mis_q;
`else
  assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed self-checking bench for lsu_bus_if.
// Expected values are hand-computed per vector.
module tb_lsu_bus_if;

  logic        clk = 1'b0;
  logic        arst;
  logic        lsu_valid_i;
  logic        lsu_is_load_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        flush_i;
  logic        stall_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        mem_r_ena_o;
  logic [31:0] mem_r_data_o;
  logic [31:0] mem_r_addr_o;
  logic        lsu_done_o;
  logic        misalign_o;

  int n_chk = 0;
  int n_fail = 0;

  lsu_bus_if dut (
    .clk          (clk),
    .arst         (arst),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_is_load_i(lsu_is_load_i),
    .lsu_funct3_i (lsu_funct3_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_be_o     (bus_be_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .mem_r_ena_o  (mem_r_ena_o),
    .mem_r_data_o (mem_r_data_o),
    .mem_r_addr_o (mem_r_addr_o),
    .lsu_done_o   (lsu_done_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    lsu_valid_i   = 1'b1;
    lsu_is_load_i = ld;
    lsu_funct3_i  = f3;
    lsu_addr_i    = a;
    lsu_wdata_i   = wd;
  endtask

  task automatic idle_in();
    lsu_valid_i = 1'b0;
    lsu_addr_i  = '0;
    lsu_wdata_i = '0;
  endtask

  // load with immediate gnt and rvalid one cycle later
  task automatic simple_load(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] rd,
                             input logic [31:0] exp);
    issue(1'b1, f3, a, 32'h0);
    step();
    idle_in();
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = rd;
    step();
    bus_rvalid_i = 1'b0;
    check({tag, "_ena"}, {31'h0, mem_r_ena_o}, 32'h1);
    check({tag, "_data"}, mem_r_data_o, exp);
    step();
  endtask

  initial begin
    arst = 1'b1;
    flush_i = 1'b0;
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i = '0;
    lsu_is_load_i = 1'b0;
    lsu_funct3_i = '0;
    idle_in();
    #12;
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    check("rst_req", {31'h0, bus_req_o}, 32'h0);
    check("rst_done", {31'h0, lsu_done_o}, 32'h0);
    check("rst_data", mem_r_data_o, 32'h0);
    check("rst_addr", bus_addr_o, 32'h0);
    @(negedge clk);
    arst = 1'b0;
    step();

    // LB at 0x1003, rdata 0x80FF_1234
    issue(1'b1, 3'b000, 32'h0000_1003, 32'h0);
    #1;
    check("lb_stall_T", {31'h0, stall_o}, 32'h1);
    step();
    idle_in();
    bus_gnt_i = 1'b1;
    #1;
    check("lb_req", {31'h0, bus_req_o}, 32'h1);
    check("lb_baddr", bus_addr_o, 32'h0000_1000);
    check("lb_we", {31'h0, bus_we_o}, 32'h0);
    check("lb_stall_T1", {31'h0, stall_o}, 32'h1);
    step();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h80FF_1234;
    check("lb_wait_req", {31'h0, bus_req_o}, 32'h0);
    check("lb_stall_T2", {31'h0, stall_o}, 32'h1);
    check("lb_ena_T2", {31'h0, mem_r_ena_o}, 32'h0);
    step();
    bus_rvalid_i = 1'b0;
    check("lb_ena_T3", {31'h0, mem_r_ena_o}, 32'h1);
    check("lb_done_T3", {31'h0, lsu_done_o}, 32'h1);
    check("lb_data", mem_r_data_o, 32'hFFFF_FF80);
    check("lb_raddr", mem_r_addr_o, 32'h0000_1003);
    check("lb_stall_T3", {31'h0, stall_o}, 32'h0);
    step();
    check("lb_ena_T4", {31'h0, mem_r_ena_o}, 32'h0);
    check("lb_data_T4", mem_r_data_o, 32'h0);

    // SH at 0x2002, wdata 0xABCD
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h0000_ABCD);
    step();
    idle_in();
    bus_gnt_i = 1'b1;
    #1;
    check("sh_be", {28'h0, bus_be_o}, 32'hC);
    check("sh_wdata", bus_wdata_o, 32'hABCD_ABCD);
    check("sh_baddr", bus_addr_o, 32'h0000_2000);
    check("sh_we", {31'h0, bus_we_o}, 32'h1);
    step();
    bus_gnt_i = 1'b0;
    check("sh_done", {31'h0, lsu_done_o}, 32'h1);
    check("sh_ena", {31'h0, mem_r_ena_o}, 32'h0);
    step();
    check("sh_done_off", {31'h0, lsu_done_o}, 32'h0);

    // SB at 0x41: lane 1
    issue(1'b0, 3'b000, 32'h0000_0041, 32'h1234_565A);
    step();
    idle_in();
    bus_gnt_i = 1'b1;
    #1;
    check("sb_be", {28'h0, bus_be_o}, 32'h2);
    check("sb_wdata", bus_wdata_o, 32'h5A5A_5A5A);
    step();
    bus_gnt_i = 1'b0;
    step();

    // LHU at 0x10, gnt withheld 3 cycles
    issue(1'b1, 3'b101, 32'h0000_0010, 32'h0);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      check("lhu_req_hold", {31'h0, bus_req_o}, 32'h1);
      check("lhu_addr_hold", bus_addr_o, 32'h0000_0010);
      check("lhu_stall_hold", {31'h0, stall_o}, 32'h1);
      step();
    end
    bus_gnt_i = 1'b1;
    #1;
    check("lhu_req_gnt", {31'h0, bus_req_o}, 32'h1);
    check("lhu_addr_gnt", bus_addr_o, 32'h0000_0010);
    step();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h1234_F00D;
    check("lhu_stall_wait", {31'h0, stall_o}, 32'h1);
    step();
    bus_rvalid_i = 1'b0;
    check("lhu_data", mem_r_data_o, 32'h0000_F00D);
    check("lhu_ena", {31'h0, mem_r_ena_o}, 32'h1);
    step();

    // LH sign extend from upper half
    simple_load("lh", 3'b001, 32'h0000_0002, 32'h8001_0000, 32'hFFFF_8001);

    // LW flushed in WAIT
    issue(1'b1, 3'b010, 32'h0000_0020, 32'h0);
    step();
    idle_in();
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    flush_i   = 1'b1;
    #1;
    check("fl_stall_on", {31'h0, stall_o}, 32'h1);
    step();
    flush_i = 1'b0;
    check("fl_stall_off", {31'h0, stall_o}, 32'h0);
    check("fl_done_drain", {31'h0, lsu_done_o}, 32'h0);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEAD_BEEF;
    step();
    bus_rvalid_i = 1'b0;
    check("fl_done", {31'h0, lsu_done_o}, 32'h0);
    check("fl_ena", {31'h0, mem_r_ena_o}, 32'h0);
    check("fl_data", mem_r_data_o, 32'h0);
    step();
    check("fl_data2", mem_r_data_o, 32'h0);
    simple_load("fl_next", 3'b010, 32'h0000_0024, 32'h1122_3344,
                32'h1122_3344);

    // flush in REQ before gnt aborts
    issue(1'b0, 3'b010, 32'h0000_0030, 32'h5555_AAAA);
    step();
    idle_in();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("abort_req", {31'h0, bus_req_o}, 32'h0);
    check("abort_done", {31'h0, lsu_done_o}, 32'h0);

    // flush in IDLE blocks acceptance
    issue(1'b1, 3'b010, 32'h0000_0030, 32'h0);
    flush_i = 1'b1;
    #1;
    check("idle_fl_stall", {31'h0, stall_o}, 32'h0);
    step();
    idle_in();
    flush_i = 1'b0;
    check("idle_fl_req", {31'h0, bus_req_o}, 32'h0);

    // invalid store funct3: straight to done, no bus
    issue(1'b0, 3'b011, 32'h0000_0040, 32'h0);
    step();
    idle_in();
    check("bad_done", {31'h0, lsu_done_o}, 32'h1);
    check("bad_req", {31'h0, bus_req_o}, 32'h0);
    step();

    // LW at 0x6
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 3'b010, 32'h0000_0006, 32'h0);
    step();
    idle_in();
    check("mis_req", {31'h0, bus_req_o}, 32'h0);
    check("mis_flag", {31'h0, misalign_o}, 32'h1);
    check("mis_done", {31'h0, lsu_done_o}, 32'h1);
    check("mis_ena", {31'h0, mem_r_ena_o}, 32'h0);
    step();
`else
    issue(1'b1, 3'b010, 32'h0000_0006, 32'h0);
    step();
    idle_in();
    check("al_baddr", bus_addr_o, 32'h0000_0004);
    check("al_mis", {31'h0, misalign_o}, 32'h0);
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hCAFE_F00D;
    step();
    bus_rvalid_i = 1'b0;
    check("al_data", mem_r_data_o, 32'hCAFE_F00D);
    check("al_raddr", mem_r_addr_o, 32'h0000_0004);
    step();
`endif

    // reset while in WAIT
    issue(1'b1, 3'b010, 32'h0000_0050, 32'h0);
    step();
    idle_in();
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    #2;
    arst = 1'b1;
    #1;
    check("ar_stall", {31'h0, stall_o}, 32'h0);
    check("ar_req", {31'h0, bus_req_o}, 32'h0);
    check("ar_data", mem_r_data_o, 32'h0);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h7777_7777;
    @(negedge clk);
    arst = 1'b0;
    step();
    bus_rvalid_i = 1'b0;
    check("ar_done", {31'h0, lsu_done_o}, 32'h0);
    check("ar_ena", {31'h0, mem_r_ena_o}, 32'h0);
    step();
    check("ar_data2", mem_r_data_o, 32'h0);
    check("ar_done2", {31'h0, lsu_done_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_if.md
Name: lsu_bus_if

Overview:
- Load/store unit that sits directly upstream of the MEM stage.
- Takes one decoded load/store per transaction from the EX/MEM side and drives a req/gnt/rvalid data-memory bus.
- Performs byte-lane steering, byte enables and load sign/zero extension.
- Delivers the final read word (mem_r_data), address and enable to the MEM stage, and stalls the pipeline while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, byte address width (matches the codebase memory address width).
- DATA_W, 32, bus and register data width; fixed to 32, no other value is supported.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- lsu_valid_i  in  1  EX/MEM holds a memory instruction this cycle
- lsu_is_load_i  in  1  1 = load, 0 = store (meaningful only with lsu_valid_i)
- lsu_funct3_i  in  3  RV32I funct3 of the load/store
- lsu_addr_i  in  32  effective byte address (rs1 + imm)
- lsu_wdata_i  in  32  store data (rs2)
- flush_i  in  1  kill the current memory instruction
- stall_o  out  1  hold IF..EX/MEM
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_be_o  out  4  byte enables
- bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata_o  out  32  lane-steered write data
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  raw read word
- mem_r_ena_o  out  1  one-cycle pulse: extended load data valid for the MEM stage
- mem_r_data_o  out  32  extended load data
- mem_r_addr_o  out  32  byte address of the completed load
- lsu_done_o  out  1  one-cycle pulse: load or store completed
- misalign_o  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset (arst high, async): state IDLE. Every output is 0, including the captured registers.
- States:
  - IDLE: if lsu_valid_i & !flush_i, capture is_load, funct3, addr, wdata; assert stall_o combinationally; go to REQ. Invalid funct3 (load 011/110/111, store 011–111): no bus access; go straight to DONE with data 0.
  - REQ: bus_req_o=1 and bus fields from the captured regs, held stable until gnt. stall_o=1.
    - gnt & store → DONE.
    - gnt & load → WAIT.
  - WAIT: bus_req_o=0, stall_o=1. On bus_rvalid_i, register the extended data → DONE.
  - DONE: lsu_done_o=1 for exactly one cycle. For loads, mem_r_ena_o=1 and mem_r_data_o/mem_r_addr_o are valid in this cycle. stall_o=0. Go to IDLE. No new capture occurs in DONE, so the same instruction is never re-accepted.
- The bus guarantees bus_rvalid_i no earlier than the cycle after gnt. rvalid seen in REQ or IDLE is ignored.
- Latency with gnt in the first REQ cycle and rvalid one cycle later:
  - load: accept T, done T+3.
  - store: accept T, done T+2.
- Store steering:
  - SB (000): be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH (001): be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW (010): be = 1111.
- Load extraction: byte lane addr[1:0], half lane addr[1].
  - LB (000) sign-extends; LBU (100) zero-extends.
  - LH (001) sign-extends; LHU (101) zero-extends.
  - LW (010) passes the word through.
- Flush:
  - In IDLE: flush_i blocks acceptance.
  - In REQ before gnt: abort, return to IDLE, no done pulse.
  - In REQ on the gnt cycle, or in WAIT: the bus transaction must complete. Set a flushed flag, drain rvalid (loads), then IDLE. No done, ena or data pulse; stall_o drops the cycle after flush_i.
- Outside the DONE cycle, mem_r_ena_o=0 and mem_r_data_o=0. Data outputs are registered.
- Reset mid-transaction returns to IDLE immediately. The bus is expected to be reset by the same arst.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access (half with addr[0]=1, word with addr[1:0]≠0) issues no bus request. The unit goes IDLE→DONE with lsu_done_o=1, misalign_o=1, mem_r_ena_o=0 and data 0.
- Undefined: the low address bits are forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally. misalign_o is tied to 0.

Test Plan:
- LB at addr 0x0000_1003, rdata 0x80FF_1234, gnt immediate, rvalid +1:
  - mem_r_data_o = 0xFFFF_FF80, mem_r_ena_o pulse at T+3, stall_o high T..T+2.
- SH at 0x0000_2002, wdata 0x0000_ABCD:
  - bus_be_o = 1100, bus_wdata_o = 0xABCD_ABCD, bus_addr_o = 0x0000_2000, lsu_done_o at T+2, no mem_r_ena_o.
- LHU at 0x10, gnt withheld 3 cycles, rdata 0x1234_F00D:
  - bus_req_o/bus_addr_o stable for 4 cycles, result 0x0000_F00D, stall_o high throughout.
- LW with flush_i asserted in the WAIT state, rdata 0xDEAD_BEEF:
  - no lsu_done_o or mem_r_ena_o, mem_r_data_o stays 0, next load accepted normally.
- LW at 0x0000_0006:
  - with LSU_MISALIGN_TRAP_EN: no bus_req_o, misalign_o and lsu_done_o pulse at T+1.
  - without: bus_addr_o = 0x0000_0004.
- arst asserted while in WAIT:
  - all outputs 0 asynchronously, state IDLE, late rvalid ignored.
